// File: rtl/bloom_word_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bloom_word_ctrl_pkg: FSM states and hash constants for the word ctrl |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bloom_word_ctrl_pkg;

   localparam int HASH_W = 8;
   localparam logic [HASH_W-1:0] c_hash_init = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCUM  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_REPORT = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/bloom_word_ctrl_word_hash.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_hash: rotate-xor (h1) and additive (h2) byte hashes of a word   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module word_hash
   import bloom_word_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              step,
   input  logic [7:0]        data,
   output logic [HASH_W-1:0] h1_next,
   output logic [HASH_W-1:0] h2_next
);

   logic [HASH_W-1:0] r_h1;
   logic [HASH_W-1:0] r_h2;
   logic [HASH_W-1:0] w_h1_base;
   logic [HASH_W-1:0] w_h2_base;

   // The first byte of a word folds into the init value, not the stale hash.
   always_comb begin
      w_h1_base = start ? c_hash_init : r_h1;
      w_h2_base = start ? c_hash_init : r_h2;
      h1_next   = {w_h1_base[HASH_W-2:0], w_h1_base[HASH_W-1]} ^ data;
      h2_next   = w_h2_base + data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_h1 <= c_hash_init;
         r_h2 <= c_hash_init;
      end else if (step) begin
         r_h1 <= h1_next;
         r_h2 <= h2_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bloom_word_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bloom_word_ctrl: streams word bytes, hashes them and drives an       |
// | external Bloom filter for load/check, with hit statistics. Rev 1.0   |
// +----------------------------------------------------------------------+
module bloom_word_ctrl
   import bloom_word_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   input  logic              mode,
   input  logic              clear,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_hit,
   output logic              bf_enable,
   output logic              bf_write,
   output logic              bf_check,
   output logic              bf_clear,
   output logic [HASH_W-1:0] bf_hash1,
   output logic [HASH_W-1:0] bf_hash2,
   input  logic              bf_word_detected,
   output logic [CNT_W-1:0]  words_loaded,
   output logic [CNT_W-1:0]  hits
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   state_t            r_state;
   logic              r_mode;
   logic              w_xfer;
   logic              w_start;
   logic              w_issue;
   logic              w_mode_eff;
   logic [HASH_W-1:0] w_h1_next;
   logic [HASH_W-1:0] w_h2_next;

   assign s_ready    = reset_n && (((r_state == ST_IDLE) && !clear) || (r_state == ST_ACCUM));
   assign w_xfer     = s_valid && s_ready;
   assign w_start    = (r_state == ST_IDLE);
   assign w_issue    = w_xfer && s_last;
   assign w_mode_eff = w_start ? mode : r_mode;

   word_hash u_word_hash (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (w_start),
      .step    (w_xfer),
      .data    (s_data),
      .h1_next (w_h1_next),
      .h2_next (w_h2_next)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_mode       <= 1'b0;
         m_valid      <= 1'b0;
         m_hit        <= 1'b0;
         bf_enable    <= 1'b0;
         bf_write     <= 1'b0;
         bf_check     <= 1'b0;
         bf_clear     <= 1'b0;
         bf_hash1     <= c_hash_init;
         bf_hash2     <= c_hash_init;
         words_loaded <= '0;
         hits         <= '0;
      end else begin
         bf_enable <= 1'b0;
         bf_write  <= 1'b0;
         bf_check  <= 1'b0;
         bf_clear  <= 1'b0;

         // Strobes are registered so they appear exactly during ISSUE.
         if (w_issue) begin
            bf_enable <= 1'b1;
            bf_write  <= w_mode_eff;
            bf_check  <= !w_mode_eff;
            bf_hash1  <= w_h1_next;
            bf_hash2  <= w_h2_next;
         end

         case (r_state)
            ST_IDLE: begin
               if (clear) begin
                  bf_clear     <= 1'b1;
                  words_loaded <= '0;
                  hits         <= '0;
               end else if (w_xfer) begin
                  r_mode  <= mode;
                  r_state <= s_last ? ST_ISSUE : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (w_issue) r_state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (r_mode) begin
                  if (words_loaded != c_cnt_max) words_loaded <= words_loaded + 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               m_hit   <= bf_word_detected;
               m_valid <= 1'b1;
               if (bf_word_detected && (hits != c_cnt_max)) hits <= hits + 1'b1;
               r_state <= ST_REPORT;
            end
            ST_REPORT: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bloom_word_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bloom_word_ctrl: random load/check words against a filter model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bloom_word_ctrl;

   localparam int TB_CNT_W = 3;
   localparam int c_sat    = (1 << TB_CNT_W) - 1;

   logic                clock = 1'b0;
   logic                reset_n;
   logic                s_valid, s_ready, s_last, mode, clear;
   logic [7:0]          s_data;
   logic                m_valid, m_ready, m_hit;
   logic                bf_enable, bf_write, bf_check, bf_clear;
   logic [7:0]          bf_hash1, bf_hash2;
   logic                bf_word_detected = 1'b0;
   logic [TB_CNT_W-1:0] words_loaded, hits;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_loaded = 0;
   int exp_hits   = 0;
   logic [255:0] dict_bits = '0;
   logic [255:0] fbits     = '0;
   logic [7:0]   wbuf [0:15];
   int           wlen;

   always #5 clock = ~clock;

   bloom_word_ctrl #(.CNT_W(TB_CNT_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .mode(mode), .clear(clear),
      .m_valid(m_valid), .m_ready(m_ready), .m_hit(m_hit),
      .bf_enable(bf_enable), .bf_write(bf_write), .bf_check(bf_check), .bf_clear(bf_clear),
      .bf_hash1(bf_hash1), .bf_hash2(bf_hash2), .bf_word_detected(bf_word_detected),
      .words_loaded(words_loaded), .hits(hits)
   );

   // External filter: one 256-bit array indexed by both hashes, result one cycle after check.
   always @(posedge clock) begin
      if (bf_clear) fbits <= '0;
      else if (bf_enable && bf_write) begin
         fbits[bf_hash1] <= 1'b1;
         fbits[bf_hash2] <= 1'b1;
      end
      bf_word_detected <= bf_enable && bf_check && fbits[bf_hash1] && fbits[bf_hash2];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_hash(output logic [7:0] eh1, output logic [7:0] eh2);
      int a, b;
      a = 0;
      b = 0;
      for (int i = 0; i < wlen; i++) begin
         a = (((a * 2) % 256) + (a / 128)) ^ int'(wbuf[i]);
         b = (b + int'(wbuf[i])) % 256;
      end
      eh1 = a[7:0];
      eh2 = b[7:0];
   endtask

   // Entered and left on a falling edge with the DUT idle.
   task automatic run_word(input logic md, input int hold, input logic clr_wait);
      logic [7:0] eh1, eh2;
      logic       ehit;
      ref_hash(eh1, eh2);
      for (int i = 0; i < wlen; i++) begin
         int guard;
         guard   = 0;
         s_valid = 1'b1;
         s_data  = wbuf[i];
         s_last  = (i == wlen - 1);
         mode    = md;
         #1;
         while (!s_ready && guard < 20) begin
            @(negedge clock);
            #1;
            guard++;
         end
         if (guard >= 20) check_eq("accept_timeout", 32'(guard), 0);
         @(negedge clock);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      check_eq("issue_enable", 32'(bf_enable), 1);
      check_eq("issue_write",  32'(bf_write), 32'(md));
      check_eq("issue_check",  32'(bf_check), 32'(!md));
      check_eq("issue_hash1",  32'(bf_hash1), 32'(eh1));
      check_eq("issue_hash2",  32'(bf_hash2), 32'(eh2));
      if (md) begin
         dict_bits[eh1] = 1'b1;
         dict_bits[eh2] = 1'b1;
         if (exp_loaded < c_sat) exp_loaded++;
         @(negedge clock);
         check_eq("load_strobe_off", 32'({bf_enable, bf_write, bf_check}), 0);
         check_eq("words_loaded", 32'(words_loaded), 32'(exp_loaded));
         check_eq("load_no_result", 32'(m_valid), 0);
         check_eq("hash1_held", 32'(bf_hash1), 32'(eh1));
         check_eq("ready_after_load", 32'(s_ready), 1);
      end else begin
         ehit = dict_bits[eh1] && dict_bits[eh2];
         if (ehit && exp_hits < c_sat) exp_hits++;
         @(negedge clock);
         check_eq("wait_no_valid", 32'(m_valid), 0);
         check_eq("wait_strobe_off", 32'({bf_enable, bf_check}), 0);
         if (clr_wait) clear = 1'b1;
         @(negedge clock);
         clear = 1'b0;
         check_eq("report_valid", 32'(m_valid), 1);
         check_eq("report_hit", 32'(m_hit), 32'(ehit));
         check_eq("hits", 32'(hits), 32'(exp_hits));
         check_eq("loaded_kept", 32'(words_loaded), 32'(exp_loaded));
         check_eq("no_clear_in_wait", 32'(bf_clear), 0);
         for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            check_eq("hold_valid", 32'(m_valid), 1);
            check_eq("hold_hit", 32'(m_hit), 32'(ehit));
            check_eq("hold_not_ready", 32'(s_ready), 0);
         end
         m_ready = 1'b1;
         @(negedge clock);
         m_ready = 1'b0;
         check_eq("report_done", 32'(m_valid), 0);
         check_eq("idle_ready", 32'(s_ready), 1);
         check_eq("no_late_clear", 32'(bf_clear), 0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
      mode = 1'b0; clear = 1'b0; m_ready = 1'b0;
      #3;
      check_eq("rst_ready", 32'(s_ready), 0);
      check_eq("rst_valid_hit", 32'({m_valid, m_hit}), 0);
      check_eq("rst_bf", 32'({bf_enable, bf_write, bf_check, bf_clear}), 0);
      check_eq("rst_hash", 32'({bf_hash1, bf_hash2}), 0);
      check_eq("rst_counters", 32'({words_loaded, hits}), 0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Load "ab", check "ab" (hit) and "ba" (miss) with a long stall and clear during WAIT.
      wlen = 2; wbuf[0] = 8'h61; wbuf[1] = 8'h62;
      run_word(1'b1, 0, 1'b0);
      run_word(1'b0, 0, 1'b0);
      wbuf[0] = 8'h62; wbuf[1] = 8'h61;
      run_word(1'b0, 5, 1'b1);

      // Clear wins over a simultaneous byte.
      clear = 1'b1; s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0; mode = 1'b1;
      #1;
      check_eq("clear_blocks_ready", 32'(s_ready), 0);
      @(negedge clock);
      clear = 1'b0; s_valid = 1'b0;
      dict_bits = '0; exp_loaded = 0; exp_hits = 0;
      check_eq("clear_pulse", 32'(bf_clear), 1);
      check_eq("clear_counters", 32'({words_loaded, hits}), 0);
      @(negedge clock);
      check_eq("clear_one_cycle", 32'(bf_clear), 0);
      wlen = 1; wbuf[0] = 8'h33;
      run_word(1'b1, 0, 1'b0);

      // Randomized traffic over a small alphabet so hits and saturation occur.
      for (int w = 0; w < 60; w++) begin
         wlen = $urandom_range(1, 3);
         for (int i = 0; i < wlen; i++) wbuf[i] = 8'($urandom_range(8'h61, 8'h64));
         if ($urandom_range(0, 3) == 0) @(negedge clock);
         run_word($urandom_range(0, 2) == 0, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
      end

      // Asynchronous reset in the middle of a word.
      s_valid = 1'b1; s_data = 8'h10; s_last = 1'b0; mode = 1'b0;
      @(negedge clock);
      s_data = 8'h20;
      @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst_ready", 32'(s_ready), 0);
      check_eq("arst_outputs", 32'({m_valid, m_hit, bf_enable, bf_write, bf_check, bf_clear}), 0);
      check_eq("arst_counters", 32'({words_loaded, hits}), 0);
      check_eq("arst_hash", 32'({bf_hash1, bf_hash2}), 0);
      s_valid = 1'b0;
      exp_loaded = 0; exp_hits = 0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      wlen = 2; wbuf[0] = 8'h61; wbuf[1] = 8'h62;
      run_word(1'b1, 0, 1'b0);
      run_word(1'b0, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
